// File: rtl/wb_scoreboard.sv
// Issue-side register scoreboard for the dual-issue pipeline: tracks per-register
// in-flight write counts and derives per-slot issue permission.
module wb_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned TOT_W    = 7
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                valid0_i,
  input  logic                valid1_i,
  input  logic [ADDR_W-1:0]   rs1_0_i,
  input  logic [ADDR_W-1:0]   rs2_0_i,
  input  logic [ADDR_W-1:0]   rs1_1_i,
  input  logic [ADDR_W-1:0]   rs2_1_i,
  input  logic [1:0]          rs_use0_i,
  input  logic [1:0]          rs_use1_i,
  input  logic [ADDR_W-1:0]   rd0_i,
  input  logic [ADDR_W-1:0]   rd1_i,
  input  logic                rdwe0_i,
  input  logic                rdwe1_i,
  input  logic                fire0_i,
  input  logic                fire1_i,
  input  logic                rfwe1_i,
  input  logic                rfwe2_i,
  input  logic [ADDR_W-1:0]   rfwaddr1_i,
  input  logic [ADDR_W-1:0]   rfwaddr2_i,
  input  logic                flush_i,
  output logic                issue_ok0_o,
  output logic                issue_ok1_o,
  output logic [NUM_REGS-1:0] busy_vec_o,
  output logic [TOT_W-1:0]    inflight_o,
  output logic                idle_o,
  output logic                err_o
);

  localparam int unsigned MaxCnt = (1 << CNT_W) - 1;
  // Wide enough for cnt + two increments before the decrements are taken off.
  localparam int unsigned SumW   = CNT_W + 2;

  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic [TOT_W-1:0]    inflight_q, inflight_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] busy;

  logic              src_busy0, src_busy1, raw1;
  logic              rd0_live, rd1_live;
  logic              cap0, cap1;
  logic [CNT_W:0]    rd1_load;
  logic              inc0, inc1, dec1, dec2;
  logic [SumW-1:0]   up, dn;

  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      busy[r] = (cnt_q[r] != '0);
    end
  end

  // Readiness looks only at registered counts; a same-cycle writeback does not bypass.
  always_comb begin
    src_busy0 = (rs_use0_i[0] && rs1_0_i != '0 && busy[rs1_0_i]) ||
                (rs_use0_i[1] && rs2_0_i != '0 && busy[rs2_0_i]);
    src_busy1 = (rs_use1_i[0] && rs1_1_i != '0 && busy[rs1_1_i]) ||
                (rs_use1_i[1] && rs2_1_i != '0 && busy[rs2_1_i]);
    rd0_live  = rdwe0_i && (rd0_i != '0);
    rd1_live  = rdwe1_i && (rd1_i != '0);
    raw1      = rd0_live && ((rs_use1_i[0] && rs1_1_i == rd0_i) ||
                             (rs_use1_i[1] && rs2_1_i == rd0_i));
    cap0      = !rd0_live || (cnt_q[rd0_i] < CNT_W'(MaxCnt));
    rd1_load  = {1'b0, cnt_q[rd1_i]} + (CNT_W+1)'(rd0_live && rd0_i == rd1_i);
    cap1      = !rd1_live || (rd1_load < (CNT_W+1)'(MaxCnt));

    issue_ok0_o = valid0_i && !src_busy0 && cap0;
    issue_ok1_o = valid1_i && issue_ok0_o && !src_busy1 && !raw1 && cap1;

    inc0 = fire0_i && issue_ok0_o && rd0_live;
    inc1 = fire0_i && fire1_i && issue_ok1_o && rd1_live;
    dec1 = rfwe1_i && (rfwaddr1_i != '0);
    dec2 = rfwe2_i && (rfwaddr2_i != '0);
  end

  always_comb begin
    err_d      = err_q;
    inflight_d = '0;
    up         = '0;
    dn         = '0;
    cnt_d[0]   = '0;
    for (int unsigned r = 1; r < NUM_REGS; r++) begin
      up = SumW'(cnt_q[r]) + SumW'(inc0 && rd0_i == ADDR_W'(r))
                           + SumW'(inc1 && rd1_i == ADDR_W'(r));
      dn = SumW'(dec1 && rfwaddr1_i == ADDR_W'(r))
         + SumW'(dec2 && rfwaddr2_i == ADDR_W'(r));
      if (dn > up) begin
        cnt_d[r] = '0;
        err_d    = 1'b1;
      end else begin
        cnt_d[r] = CNT_W'(up - dn);
      end
      if (flush_i) begin
        cnt_d[r] = '0;
      end
      inflight_d = inflight_d + TOT_W'(cnt_d[r]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= '0;
      end
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy_vec_o = busy;
  assign inflight_o = inflight_q;
  assign idle_o     = (inflight_q == '0);
  assign err_o      = err_q;

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: directed scenarios plus a randomized run against a
// count-per-register reference model.
module tb_wb_scoreboard;

  localparam int NR  = 32;
  localparam int MAX = 3;

  logic        clk = 1'b0;
  logic        rst, valid0, valid1, rdwe0, rdwe1, fire0, fire1, rfwe1, rfwe2, flush;
  logic [4:0]  rs1_0, rs2_0, rs1_1, rs2_1, rd0, rd1, rfwaddr1, rfwaddr2;
  logic [1:0]  rs_use0, rs_use1;
  logic        ok0, ok1, idle, err;
  logic [31:0] busy_vec;
  logic [6:0]  inflight;

  int vecs = 0;
  int errs = 0;
  int mcnt [NR];
  bit merr;

  always #5 clk = ~clk;

  wb_scoreboard dut (
    .clk_i(clk), .rst_i(rst), .valid0_i(valid0), .valid1_i(valid1),
    .rs1_0_i(rs1_0), .rs2_0_i(rs2_0), .rs1_1_i(rs1_1), .rs2_1_i(rs2_1),
    .rs_use0_i(rs_use0), .rs_use1_i(rs_use1), .rd0_i(rd0), .rd1_i(rd1),
    .rdwe0_i(rdwe0), .rdwe1_i(rdwe1), .fire0_i(fire0), .fire1_i(fire1),
    .rfwe1_i(rfwe1), .rfwe2_i(rfwe2), .rfwaddr1_i(rfwaddr1), .rfwaddr2_i(rfwaddr2),
    .flush_i(flush), .issue_ok0_o(ok0), .issue_ok1_o(ok1), .busy_vec_o(busy_vec),
    .inflight_o(inflight), .idle_o(idle), .err_o(err)
  );

  task automatic clear_in();
    rst = 0; valid0 = 0; valid1 = 0; rdwe0 = 0; rdwe1 = 0; fire0 = 0; fire1 = 0;
    rfwe1 = 0; rfwe2 = 0; flush = 0; rs1_0 = 0; rs2_0 = 0; rs1_1 = 0; rs2_1 = 0;
    rd0 = 0; rd1 = 0; rfwaddr1 = 0; rfwaddr2 = 0; rs_use0 = 0; rs_use1 = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a register is busy while it has any pending write.
  function automatic bit m_busy(logic [4:0] a);
    return a != 0 && mcnt[int'(a)] != 0;
  endfunction

  function automatic bit m_ok0();
    bit srcs_free = !(rs_use0[0] && m_busy(rs1_0)) && !(rs_use0[1] && m_busy(rs2_0));
    bit room = !rdwe0 || rd0 == 0 || mcnt[int'(rd0)] < MAX;
    return valid0 && srcs_free && room;
  endfunction

  function automatic bit m_ok1();
    bit srcs_free = !(rs_use1[0] && m_busy(rs1_1)) && !(rs_use1[1] && m_busy(rs2_1));
    bit w0 = rdwe0 && rd0 != 0;
    bit raw = w0 && ((rs_use1[0] && rs1_1 == rd0) || (rs_use1[1] && rs2_1 == rd0));
    int pend = mcnt[int'(rd1)] + ((w0 && rd0 == rd1) ? 1 : 0);
    bit room = !rdwe1 || rd1 == 0 || pend < MAX;
    return valid1 && m_ok0() && srcs_free && !raw && room;
  endfunction

  task automatic m_step();
    bit i0 = fire0 && m_ok0() && rdwe0 && rd0 != 0;
    bit i1 = fire0 && fire1 && m_ok1() && rdwe1 && rd1 != 0;
    for (int r = 1; r < NR; r++) begin
      int v = mcnt[r];
      v += (i0 && int'(rd0) == r) ? 1 : 0;
      v += (i1 && int'(rd1) == r) ? 1 : 0;
      v -= (rfwe1 && int'(rfwaddr1) == r) ? 1 : 0;
      v -= (rfwe2 && int'(rfwaddr2) == r) ? 1 : 0;
      if (v < 0) begin
        merr = 1;
        v = 0;
      end
      mcnt[r] = flush ? 0 : v;
    end
  endtask

  task automatic test_reset();
    clear_in(); rst = 1; tick(); rst = 0;
    valid0 = 1; rs1_0 = 5; rs_use0 = 2'b01; #1;
    vecs++; if (ok0 !== 1'b1) begin errs++; $display("FAIL reset_ok0: got %b want 1", ok0); end
    vecs++; if (busy_vec !== 32'h0) begin errs++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    vecs++; if (inflight !== 7'd0) begin errs++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
    vecs++; if (idle !== 1'b1) begin errs++; $display("FAIL reset_idle: got %b want 1", idle); end
    vecs++; if (err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_raw();
    clear_in(); valid0 = 1; rd0 = 3; rdwe0 = 1; fire0 = 1; tick(); clear_in();
    vecs++; if (busy_vec !== 32'h8) begin errs++; $display("FAIL raw_busy: got %h want 8", busy_vec); end
    vecs++; if (inflight !== 7'd1) begin errs++; $display("FAIL raw_inflight: got %0d want 1", inflight); end
    valid0 = 1; rs1_0 = 3; rs_use0 = 2'b01; #1;
    vecs++; if (ok0 !== 1'b0) begin errs++; $display("FAIL raw_stall: got %b want 0", ok0); end
    rfwe1 = 1; rfwaddr1 = 3; #1;
    vecs++; if (ok0 !== 1'b0) begin errs++; $display("FAIL raw_nobypass: got %b want 0", ok0); end
    tick(); rfwe1 = 0; #1;
    vecs++; if (ok0 !== 1'b1) begin errs++; $display("FAIL raw_release: got %b want 1", ok0); end
    vecs++; if (idle !== 1'b1) begin errs++; $display("FAIL raw_idle: got %b want 1", idle); end
  endtask

  task automatic test_intra_bundle();
    clear_in(); valid0 = 1; rd0 = 7; rdwe0 = 1; valid1 = 1; rs2_1 = 7; rs_use1 = 2'b10; #1;
    vecs++; if (ok0 !== 1'b1) begin errs++; $display("FAIL intra_ok0: got %b want 1", ok0); end
    vecs++; if (ok1 !== 1'b0) begin errs++; $display("FAIL intra_raw_ok1: got %b want 0", ok1); end
    rs_use1 = 2'b01; rs1_1 = 0; rd1 = 8; rdwe1 = 1; fire0 = 1; fire1 = 1; #1;
    vecs++; if (ok1 !== 1'b1) begin errs++; $display("FAIL intra_free_ok1: got %b want 1", ok1); end
    tick(); clear_in();
    vecs++; if (inflight !== 7'd2) begin errs++; $display("FAIL intra_inflight: got %0d want 2", inflight); end
    vecs++; if (busy_vec !== 32'h180) begin errs++; $display("FAIL intra_busy: got %h want 180", busy_vec); end
    valid0 = 1; valid1 = 1; rd1 = 10; rdwe1 = 1; fire1 = 1; tick(); clear_in();
    vecs++; if (inflight !== 7'd2) begin errs++; $display("FAIL intra_fire1_alone: got %0d want 2", inflight); end
    rfwe1 = 1; rfwaddr1 = 7; rfwe2 = 1; rfwaddr2 = 8; tick(); clear_in();
    vecs++; if (idle !== 1'b1 || err !== 1'b0) begin
      errs++; $display("FAIL intra_retire: got idle=%b err=%b want idle=1 err=0", idle, err);
    end
  endtask

  task automatic test_saturation();
    clear_in(); valid0 = 1; rd0 = 4; rdwe0 = 1; fire0 = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (ok0 !== 1'b1) begin errs++; $display("FAIL sat_fill%0d: got %b want 1", i, ok0); end
      tick();
    end
    vecs++; if (ok0 !== 1'b0) begin errs++; $display("FAIL sat_full_ok0: got %b want 0", ok0); end
    vecs++; if (inflight !== 7'd3) begin errs++; $display("FAIL sat_inflight: got %0d want 3", inflight); end
    rfwe2 = 1; rfwaddr2 = 4; tick();
    vecs++; if (inflight !== 7'd2) begin errs++; $display("FAIL sat_blocked_fire: got %0d want 2", inflight); end
    #1;
    vecs++; if (ok0 !== 1'b1) begin errs++; $display("FAIL sat_room_ok0: got %b want 1", ok0); end
    tick();
    vecs++; if (inflight !== 7'd2 || busy_vec !== 32'h10) begin
      errs++; $display("FAIL sat_net_out: got %0d/%h want 2/10", inflight, busy_vec);
    end
    clear_in(); flush = 1; tick(); clear_in();
  endtask

  task automatic test_dual_dec();
    clear_in(); valid0 = 1; rd0 = 9; rdwe0 = 1; fire0 = 1; tick(); tick(); clear_in();
    vecs++; if (inflight !== 7'd2) begin errs++; $display("FAIL dual_fill: got %0d want 2", inflight); end
    rfwe1 = 1; rfwe2 = 1; rfwaddr1 = 9; rfwaddr2 = 9; tick();
    vecs++; if (busy_vec !== 32'h0 || inflight !== 7'd0 || err !== 1'b0) begin
      errs++; $display("FAIL dual_dec: got %h/%0d/%b want 0/0/0", busy_vec, inflight, err);
    end
    tick(); clear_in();
    vecs++; if (err !== 1'b1 || inflight !== 7'd0) begin
      errs++; $display("FAIL dual_underflow: got err=%b infl=%0d want 1/0", err, inflight);
    end
    flush = 1; tick(); clear_in();
    vecs++; if (err !== 1'b1) begin errs++; $display("FAIL err_sticky_flush: got %b want 1", err); end
  endtask

  task automatic test_flush();
    clear_in(); valid0 = 1; rdwe0 = 1; fire0 = 1;
    for (int i = 0; i < 5; i++) begin
      rd0 = 5'(10 + i);
      tick();
    end
    clear_in();
    vecs++; if (inflight !== 7'd5) begin errs++; $display("FAIL flush_fill: got %0d want 5", inflight); end
    flush = 1; valid0 = 1; rd0 = 2; rdwe0 = 1; fire0 = 1; tick(); clear_in();
    vecs++; if (inflight !== 7'd0 || busy_vec !== 32'h0 || idle !== 1'b1) begin
      errs++; $display("FAIL flush_clear: got %0d/%h/%b want 0/0/1", inflight, busy_vec, idle);
    end
  endtask

  task automatic test_reset_midstream();
    clear_in(); valid0 = 1; rd0 = 20; rdwe0 = 1; fire0 = 1; tick();
    clear_in(); rst = 1; valid0 = 1; rd0 = 21; rdwe0 = 1; fire0 = 1; tick(); clear_in();
    vecs++; if (inflight !== 7'd0 || busy_vec !== 32'h0 || idle !== 1'b1 || err !== 1'b0) begin
      errs++; $display("FAIL reset_mid: got %0d/%h/%b/%b want 0/0/1/0", inflight, busy_vec, idle, err);
    end
  endtask

  task automatic test_random();
    int sum;
    logic [31:0] exp_busy;
    clear_in(); rst = 1; tick(); rst = 0;
    for (int r = 0; r < NR; r++) mcnt[r] = 0;
    merr = 0;
    for (int n = 0; n < 400; n++) begin
      valid0 = $urandom_range(0, 3) != 0; valid1 = $urandom_range(0, 3) != 0;
      rs1_0 = 5'($urandom_range(0, 7)); rs2_0 = 5'($urandom_range(0, 7));
      rs1_1 = 5'($urandom_range(0, 7)); rs2_1 = 5'($urandom_range(0, 7));
      rs_use0 = 2'($urandom); rs_use1 = 2'($urandom);
      rd0 = 5'($urandom_range(0, 7)); rd1 = 5'($urandom_range(0, 7));
      rdwe0 = 1'($urandom); rdwe1 = 1'($urandom);
      fire0 = $urandom_range(0, 3) != 0; fire1 = $urandom_range(0, 3) != 0;
      rfwe1 = $urandom_range(0, 2) == 0; rfwe2 = $urandom_range(0, 3) == 0;
      rfwaddr1 = 5'($urandom_range(0, 7)); rfwaddr2 = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 39) == 0;
      #1;
      vecs++; if (ok0 !== m_ok0()) begin errs++; $display("FAIL rnd%0d_ok0: got %b want %b", n, ok0, m_ok0()); end
      vecs++; if (ok1 !== m_ok1()) begin errs++; $display("FAIL rnd%0d_ok1: got %b want %b", n, ok1, m_ok1()); end
      m_step();
      tick();
      sum = 0; exp_busy = '0;
      for (int r = 0; r < NR; r++) begin
        sum += mcnt[r];
        exp_busy[r] = mcnt[r] != 0;
      end
      vecs++; if (busy_vec !== exp_busy) begin errs++; $display("FAIL rnd%0d_busy: got %h want %h", n, busy_vec, exp_busy); end
      vecs++; if (inflight !== 7'(sum) || idle !== (sum == 0)) begin
        errs++; $display("FAIL rnd%0d_inflight: got %0d/%b want %0d", n, inflight, idle, sum);
      end
      vecs++; if (err !== merr) begin errs++; $display("FAIL rnd%0d_err: got %b want %b", n, err, merr); end
    end
  endtask

  initial begin
    clear_in();
    test_reset();
    test_raw();
    test_intra_bundle();
    test_saturation();
    test_dual_dec();
    test_flush();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
